axilite_slave_regs: RTL

AXI4-Lite responder that terminates the bus driven by the team's AXI-Lite master and exposes a bank of software-writable registers to fabric logic. Write and read channels run as independent state machines. AW and W are accepted in either order. Out-of-range accesses get SLVERR. Every committed write raises a one-cycle per-register pulse toward user logic.

---
 rtl/axilite_slave_regs.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axilite_slave_regs.sv
`default_nettype none
// ============================================================================
//  Module      : axilite_slave_regs
//  Description : AXI4-Lite responder terminating a bank of software-writable
//                registers. Independent write/read FSMs, AW/W in any order,
//                SLVERR on out-of-range index, one-cycle write pulse per reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module axilite_slave_regs #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    // write address channel
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    // write data channel
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    // write response channel
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    // read address channel
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    // read data channel
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    // fabric side
    output logic [NUM_REGS*DATA_W-1:0]   user_regs_out,
    output logic [NUM_REGS-1:0]          user_wr_pulse
);

    localparam int         STRB_W      = DATA_W / 8;
    localparam int         OFS         = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    // ------------------------------------------------------------------------
    // Storage and channel state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse;

    wstate_t             w_state;
    wstate_t             w_next;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [1:0]          bresp_q;

    rstate_t             r_state;
    rstate_t             r_next;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp_q;

    logic [ADDR_W-1:0]   aw_idx;
    logic [ADDR_W-1:0]   ar_idx;
    logic                aw_in_range;
    logic                ar_in_range;

    logic                aw_fire;
    logic                w_fire;
    logic                b_fire;
    logic                ar_fire;
    logic                r_fire;

    // Protection bits carry no meaning for this register bank.
    logic                unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // Index decode over the full address; low byte-offset bits drop out.
    assign aw_idx      = aw_addr_q >> OFS;
    assign ar_idx      = s_axi_araddr >> OFS;
    assign aw_in_range = (aw_idx < ADDR_W'(NUM_REGS));
    assign ar_in_range = (ar_idx < ADDR_W'(NUM_REGS));

    // Readies depend only on state/flags, forced low while reset is held.
    assign s_axi_awready = (w_state == W_IDLE) && !aw_held && !areset;
    assign s_axi_wready  = (w_state == W_IDLE) && !w_held  && !areset;
    assign s_axi_arready = (r_state == R_IDLE) && !areset;

    assign aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_fire  = s_axi_wvalid  && s_axi_wready;
    assign b_fire  = s_axi_bvalid  && s_axi_bready;
    assign ar_fire = s_axi_arvalid && s_axi_arready;
    assign r_fire  = s_axi_rvalid  && s_axi_rready;

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------

    // Write FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state and response valid; commit once both halves held.
    always_comb begin
        w_next       = w_state;
        s_axi_bvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    w_next = W_COMMIT;
                end
            end
            W_COMMIT: begin
                w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: begin
                w_next = W_IDLE;
            end
        endcase
    end

    // Capture AW/W independently and hold them until the B handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (b_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_fire) aw_held <= 1'b1;
                if (w_fire)  w_held  <= 1'b1;
            end
            if (aw_fire) aw_addr_q <= s_axi_awaddr;
            if (w_fire) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Response code is decided during the commit cycle and held through B.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bresp_q <= RESP_OKAY;
        end else if (w_state == W_COMMIT) begin
            bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi_bresp = bresp_q;

    // Register bank: an exact index match implies the access is in range.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic hit;
        assign hit = (w_state == W_COMMIT) && (aw_idx == ADDR_W'(i));

        // Byte-lane update of register i and its one-cycle write pulse.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                regs[i]     <= '0;
                wr_pulse[i] <= 1'b0;
            end else begin
                wr_pulse[i] <= hit;
                if (hit) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end

        assign user_regs_out[i*DATA_W +: DATA_W] = regs[i];
    end

    assign user_wr_pulse = wr_pulse;

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------

    // Read data select; an unmatched index yields zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == ADDR_W'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state and data valid.
    always_comb begin
        r_next       = r_state;
        s_axi_rvalid = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_fire) begin
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (r_fire) begin
                    r_next = R_IDLE;
                end
            end
            default: begin
                r_next = R_IDLE;
            end
        endcase
    end

    // Register read data/response on AR; held stable until R handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= rd_mux;
            rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

endmodule
`default_nettype wire
